// File: rtl/dac_mux_sequencer.sv
// dac_mux_sequencer: round-robin DAC code loader with break-before-make one-hot output demux.
// Define DAC_MUX_SEQ_TIMEOUT_EN to enable the dac_done watchdog (sticky err, channel skip).
module dac_mux_sequencer #(
    parameter int NUM_CH         = 6,
    parameter int DATA_W         = 12,
    parameter int SETTLE_CYCLES  = 16,
    parameter int HOLD_CYCLES    = 64,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int CH_W          = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] dac_code,
    output logic              dac_valid,
    input  logic              dac_ready,
    input  logic              dac_done,
    output logic [NUM_CH-1:0] mux_sel,
    output logic [CH_W-1:0]   cur_ch,
    output logic              busy,
    output logic              frame_done,
    output logic              err
);

    localparam int SH_MAX  = (SETTLE_CYCLES > HOLD_CYCLES) ? SETTLE_CYCLES : HOLD_CYCLES;
    localparam int CNT_MAX = (TIMEOUT_CYCLES > SH_MAX) ? TIMEOUT_CYCLES : SH_MAX;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_SETTLE,
        ST_HOLD
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] tbl_q [NUM_CH];
    logic [DATA_W-1:0] dac_code_q;
    logic              dac_valid_q;
    logic [NUM_CH-1:0] mux_q;
    logic [CH_W-1:0]   cur_ch_q;
    logic              busy_q;
    logic              frame_done_q;

    logic              last_ch;
    logic [CH_W-1:0]   nxt_ch;
    logic              timeout;
    logic              ch_end;

    always_comb begin
        last_ch = (cur_ch_q == CH_W'(NUM_CH - 1));
        nxt_ch  = last_ch ? '0 : cur_ch_q + CH_W'(1);
        timeout = 1'b0;
`ifdef DAC_MUX_SEQ_TIMEOUT_EN
        // dac_done arriving on the terminal count still wins over the watchdog
        timeout = (state_q == ST_WAIT) && !dac_done && (cnt_q == '0);
`endif
        ch_end  = timeout || ((state_q == ST_HOLD) && (cnt_q == '0));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                tbl_q[i] <= '0;
            end
        end else if (wr_en && ({1'b0, wr_ch} < (CH_W + 1)'(NUM_CH))) begin
            tbl_q[wr_ch] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            dac_code_q   <= '0;
            dac_valid_q  <= 1'b0;
            mux_q        <= '0;
            cur_ch_q     <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            // HOLD expiry and watchdog skip share the same channel-advance path
            if (ch_end) begin
                mux_q        <= '0;
                cur_ch_q     <= nxt_ch;
                frame_done_q <= last_ch;
                if (enable) begin
                    state_q     <= ST_LOAD;
                    dac_code_q  <= tbl_q[nxt_ch];
                    dac_valid_q <= 1'b1;
                    busy_q      <= 1'b1;
                end else begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (enable) begin
                            state_q     <= ST_LOAD;
                            dac_code_q  <= tbl_q[cur_ch_q];
                            dac_valid_q <= 1'b1;
                            busy_q      <= 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        if (dac_ready) begin
                            dac_valid_q <= 1'b0;
                            state_q     <= ST_WAIT;
                            cnt_q       <= CNT_W'(TIMEOUT_CYCLES - 1);
                        end
                    end
                    ST_WAIT: begin
                        if (dac_done) begin
                            state_q <= ST_SETTLE;
                            cnt_q   <= CNT_W'(SETTLE_CYCLES - 1);
                        end
                    end
                    ST_SETTLE: begin
                        if (cnt_q == '0) begin
                            state_q <= ST_HOLD;
                            mux_q   <= NUM_CH'(1) << cur_ch_q;
                            cnt_q   <= CNT_W'(HOLD_CYCLES - 1);
                        end
                    end
                    ST_HOLD: begin
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef DAC_MUX_SEQ_TIMEOUT_EN
    logic err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign dac_code   = dac_code_q;
    assign dac_valid  = dac_valid_q;
    assign mux_sel    = mux_q;
    assign cur_ch     = cur_ch_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule
